// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative signed multiply / divide unit.
//
// The control unit pulses `start` with `DivMult` selecting the operation
// (0 = MULT, 1 = DIV), waits for the one-cycle `done` pulse, then captures
// hi/lo and branches on the flags.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle request, only honoured while idle
//   DivMult      in   operation select, sampled with start
//   a, b         in   signed operands, sampled with start
//   busy         out  from the cycle after an accepted start through done
//   done         out  one-cycle pulse; hi/lo/flags valid from then on
//   hi, lo       out  MULT: product high/low half; DIV: remainder/quotient
//   Multoverflow out  MULT product does not fit in WIDTH signed bits
//   DivByZero    out  DIV requested with b == 0 (hi/lo left unchanged)
//
// Build option: define MDU_FAST_MULT_EN to compute MULT combinationally
// (done in the cycle after start) instead of the radix-2 Booth iteration.
// DIV is always iterative.

module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             DivMult,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             Multoverflow,
    output logic             DivByZero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_q, op_d;        // MULT: multiplicand; DIV: |divisor|
    logic [2*WIDTH:0]   prod_q, prod_d;    // Booth register {upper, lower, extra}
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;      // |dividend| shifting out, quotient in
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     upper_x, mcand_x, sum;
    logic [2*WIDTH:0]   prod_step;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic [WIDTH-1:0]   a_mag, b_mag;
`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    always_comb begin
        // Booth step: add is done one bit wider so a most-negative
        // multiplicand cannot overflow before the arithmetic shift.
        upper_x = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        mcand_x = {op_q[WIDTH-1], op_q};
        case (prod_q[1:0])
            2'b01:   sum = upper_x + mcand_x;
            2'b10:   sum = upper_x - mcand_x;
            default: sum = upper_x;
        endcase
        prod_step = {sum, prod_q[WIDTH:1]};

        // Restoring division step on magnitudes; trial[WIDTH] is the borrow.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, op_q};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b0};
        end

        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
`ifdef MDU_FAST_MULT_EN
        fast_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
`endif

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = CW'(WIDTH);
                    ovf_d = 1'b0;
                    dbz_d = 1'b0;
                    if (DivMult) begin
                        if (b == '0) begin
                            dbz_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            op_d    = b_mag;
                            quo_d   = a_mag;
                            rem_d   = '0;
                            a_neg_d = a[WIDTH-1];
                            b_neg_d = b[WIDTH-1];
                            state_d = S_DIV;
                        end
                    end else begin
`ifdef MDU_FAST_MULT_EN
                        hi_d    = fast_prod[2*WIDTH-1:WIDTH];
                        lo_d    = fast_prod[WIDTH-1:0];
                        ovf_d   = fast_prod[2*WIDTH-1:WIDTH] != {WIDTH{fast_prod[WIDTH-1]}};
                        state_d = S_DONE;
`else
                        op_d    = a;
                        prod_d  = {{WIDTH{1'b0}}, b, 1'b0};
                        state_d = S_MULT;
`endif
                    end
                end
            end
            S_MULT: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = prod_step[2*WIDTH:WIDTH+1];
                    lo_d    = prod_step[WIDTH:1];
                    ovf_d   = prod_step[2*WIDTH:WIDTH+1] != {WIDTH{prod_step[WIDTH]}};
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Truncating quotient; remainder follows the dividend's sign.
                    lo_d    = (a_neg_q ^ b_neg_q) ? -quo_next : quo_next;
                    hi_d    = a_neg_q ? -rem_next : rem_next;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign Multoverflow = ovf_q;
    assign DivByZero    = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
    localparam int MULT_LAT = 1;
`else
    localparam int MULT_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk, reset, start, DivMult;
    logic [W-1:0] a, b;
    logic         busy, done, Multoverflow, DivByZero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .DivMult(DivMult),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .Multoverflow(Multoverflow), .DivByZero(DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_seen = 0;

    always @(negedge clk) if (done) done_seen++;

    // Reference-model state: last committed hi/lo survive a divide-by-zero.
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_ovf, m_dbz;
    int           m_lat;

    typedef struct {
        logic         dm;
        logic [W-1:0] av, bv, hi, lo;
        logic         ovf, dbz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model(input logic dm, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint sa, sb, p, q, r;
        longint lim;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        lim = 64'sd2147483647;
        m_ovf = 1'b0;
        m_dbz = 1'b0;
        if (!dm) begin
            p     = sa * sb;
            m_hi  = p[63:32];
            m_lo  = p[31:0];
            m_ovf = (p > lim) || (p < -lim - 1);
            m_lat = MULT_LAT;
        end else if (bv == '0) begin
            m_dbz = 1'b1;
            m_lat = 1;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            m_lo  = q[31:0];
            m_hi  = r[31:0];
            m_lat = DIV_LAT;
        end
    endtask

    // Issue one operation and wait (bounded) for done. lat = 1 when done is
    // visible right after the accepting edge.
    task automatic run_op(input logic dm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat);
        @(negedge clk);
        start = 1'b1; DivMult = dm; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; DivMult = $urandom_range(0, 1);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input int lat, input logic [W-1:0] ehi,
                            input logic [W-1:0] elo, input logic eovf, input logic edbz,
                            input int elat);
        chk({tag, ".lat"},  64'(lat), 64'(elat));
        chk({tag, ".hi"},   64'(hi), 64'(ehi));
        chk({tag, ".lo"},   64'(lo), 64'(elo));
        chk({tag, ".ovf"},  64'(Multoverflow), 64'(eovf));
        chk({tag, ".dbz"},  64'(DivByZero), 64'(edbz));
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, 64'(done), 64'd0);
    endtask

    vec_t tbl[$];

    initial begin
        int lat, base, first, dcnt;
        logic [W-1:0] cap_hi, cap_lo;

        tbl.push_back('{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h40000000,  32'd4,        32'h00000001, 32'h00000000, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 32'd5,         32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 32'd100,       32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 32'd7,         32'd7,        32'h00000000, 32'h00000001, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h00012345,  32'd0,        32'h00000000, 32'h00000000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h0000FFFF,  32'h00010001, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0});

        reset = 1'b0; start = 1'b0; DivMult = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi",   64'(hi),   64'd0);
        chk("rst.lo",   64'(lo),   64'd0);
        chk("rst.ovf",  64'(Multoverflow), 64'd0);
        chk("rst.dbz",  64'(DivByZero),    64'd0);
        @(negedge clk); reset = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].dm, tbl[i].av, tbl[i].bv, lat);
            check_op($sformatf("vec%0d", i), lat, tbl[i].hi, tbl[i].lo, tbl[i].ovf, tbl[i].dbz,
                     (tbl[i].dm && tbl[i].bv == '0) ? 1 : (tbl[i].dm ? DIV_LAT : MULT_LAT));
            if (!tbl[i].dbz) begin
                m_hi = tbl[i].hi;
                m_lo = tbl[i].lo;
            end
        end

        // Second start at start+10 of a DIV must be ignored.
        model(1'b1, 32'd1000, 32'hFFFFFFFD);
        @(negedge clk);
        start = 1'b1; DivMult = 1'b1; a = 32'd1000; b = 32'hFFFFFFFD;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; first = 0; cap_hi = '0; cap_lo = '0;
        if (done) begin dcnt++; first = 1; end
        for (int i = 2; i <= 60; i++) begin
            @(negedge clk);
            start = (i == 11); DivMult = 1'b0; a = 32'd50; b = 32'd5;
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (first == 0) begin first = i; cap_hi = hi; cap_lo = lo; end
            end
        end
        start = 1'b0;
        chk("ign.done_count", 64'(dcnt), 64'd1);
        chk("ign.lat", 64'(first), 64'(DIV_LAT));
        chk("ign.hi", 64'(cap_hi), 64'(m_hi));
        chk("ign.lo", 64'(cap_lo), 64'(m_lo));

        // Reset five cycles into a MULT: immediate clear, no done.
        @(negedge clk);
        start = 1'b1; DivMult = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.hi",   64'(hi),   64'd0);
        chk("arst.lo",   64'(lo),   64'd0);
        chk("arst.ovf",  64'(Multoverflow), 64'd0);
        chk("arst.dbz",  64'(DivByZero),    64'd0);
        @(negedge clk); reset = 1'b1;
        base = done_seen;
        repeat (45) @(posedge clk);
        #1;
        chk("arst.no_done", 64'(done_seen - base), 64'd0);
        m_hi = '0; m_lo = '0;

        for (int i = 0; i < 40; i++) begin
            logic         dm;
            logic [W-1:0] av, bv;
            dm = 1'(($urandom & 1));
            av = $urandom;
            case ($urandom_range(0, 7))
                0:       bv = '0;
                1:       bv = 32'($urandom_range(1, 9));
                2:       bv = -32'($urandom_range(1, 9));
                3:       av = 32'($urandom_range(0, 65535));
                default: bv = $urandom;
            endcase
            if (bv === 'x) bv = $urandom;
            model(dm, av, bv);
            run_op(dm, av, bv, lat);
            check_op($sformatf("rnd%0d", i), lat, m_hi, m_lo, m_ovf, m_dbz, m_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
